// File: rtl/pipe_ctrl_hazard.sv
// pipe_ctrl_hazard: carries decoded control through the ID/EX, EX/MEM and
// MEM/WB registers, detects data hazards and drives the PC / IF/ID controls.
// Optional build macro FWD_UNIT_EN: enables the operand forwarding selects
// and restricts stalls to load-use; without it every in-flight producer
// that matches an ID source stalls the front end.
module pipe_ctrl_hazard #(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_reg_dst,
  input  logic              id_alu_src,
  input  logic              id_mem_to_reg,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_branch,
  input  logic [1:0]        id_alu_op,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_branch_taken,
  output logic              ex_reg_dst,
  output logic              ex_alu_src,
  output logic              ex_mem_to_reg,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch,
  output logic [1:0]        ex_alu_op,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_dest,
  output logic              mem_mem_to_reg,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic [REG_AW-1:0] mem_dest,
  output logic              wb_mem_to_reg,
  output logic              wb_reg_write,
  output logic [REG_AW-1:0] wb_dest,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  logic [REG_AW-1:0] idDest;
  logic              loadUse;
  logic              stallReq;
  logic              flushReq;
  logic              bubble;

  assign idDest = id_reg_dst ? id_rd : id_rt;

  // Hazard detection, forwarding selects and front-end controls
  always_comb begin
    loadUse  = ex_mem_read && (ex_dest != '0) &&
               ((ex_dest == id_rs) || (ex_dest == id_rt));
    stallReq = loadUse;
    fwd_a    = 2'b00;
    fwd_b    = 2'b00;
`ifdef FWD_UNIT_EN
    // EX/MEM result is newer than MEM/WB, so it wins when both match
    if (mem_reg_write && (mem_dest != '0) && (mem_dest == ex_rs))
      fwd_a = 2'b10;
    else if (wb_reg_write && (wb_dest != '0) && (wb_dest == ex_rs))
      fwd_a = 2'b01;
    if (mem_reg_write && (mem_dest != '0) && (mem_dest == ex_rt))
      fwd_b = 2'b10;
    else if (wb_reg_write && (wb_dest != '0) && (wb_dest == ex_rt))
      fwd_b = 2'b01;
`else
    // No bypass paths: wait until the producer has reached WB
    if (ex_reg_write && (ex_dest != '0) &&
        ((ex_dest == id_rs) || (ex_dest == id_rt)))
      stallReq = 1'b1;
    if (mem_reg_write && (mem_dest != '0) &&
        ((mem_dest == id_rs) || (mem_dest == id_rt)))
      stallReq = 1'b1;
`endif
    flushReq   = ex_branch_taken;
    bubble     = flushReq || stallReq;
    // A taken branch redirects the PC, so it overrides any stall
    pc_write   = flushReq || !stallReq;
    ifid_write = flushReq || !stallReq;
    ifid_flush = flushReq;
  end

  // ID/EX register: loads a bubble on stall or flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_reg_dst    <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_branch     <= 1'b0;
      ex_alu_op     <= 2'b00;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_dest       <= '0;
    end else if (bubble) begin
      ex_reg_dst    <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_branch     <= 1'b0;
      ex_alu_op     <= 2'b00;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_dest       <= '0;
    end else begin
      ex_reg_dst    <= id_reg_dst;
      ex_alu_src    <= id_alu_src;
      ex_mem_to_reg <= id_mem_to_reg;
      ex_reg_write  <= id_reg_write;
      ex_mem_read   <= id_mem_read;
      ex_mem_write  <= id_mem_write;
      ex_branch     <= id_branch;
      ex_alu_op     <= id_alu_op;
      ex_rs         <= id_rs;
      ex_rt         <= id_rt;
      ex_dest       <= idDest;
    end
  end

  // EX/MEM register: always advances, drops branch and ALU controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_mem_to_reg <= 1'b0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_dest       <= '0;
    end else begin
      mem_mem_to_reg <= ex_mem_to_reg;
      mem_reg_write  <= ex_reg_write;
      mem_mem_read   <= ex_mem_read;
      mem_mem_write  <= ex_mem_write;
      mem_dest       <= ex_dest;
    end
  end

  // MEM/WB register: always advances, keeps only write-back controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_mem_to_reg <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_dest       <= '0;
    end else begin
      wb_mem_to_reg <= mem_mem_to_reg;
      wb_reg_write  <= mem_reg_write;
      wb_dest       <= mem_dest;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_hazard.sv
// Directed bench for pipe_ctrl_hazard; expectations follow FWD_UNIT_EN.
module tb_pipe_ctrl_hazard;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write;
  logic          id_mem_read, id_mem_write, id_branch;
  logic [1:0]    id_alu_op;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic          ex_branch_taken;
  logic          ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write;
  logic          ex_mem_read, ex_mem_write, ex_branch;
  logic [1:0]    ex_alu_op;
  logic [AW-1:0] ex_rs, ex_rt, ex_dest;
  logic          mem_mem_to_reg, mem_reg_write, mem_mem_read, mem_mem_write;
  logic [AW-1:0] mem_dest;
  logic          wb_mem_to_reg, wb_reg_write;
  logic [AW-1:0] wb_dest;
  logic          pc_write, ifid_write, ifid_flush;
  logic [1:0]    fwd_a, fwd_b;

  int total = 0;
  int bad = 0;

  pipe_ctrl_hazard #(.REG_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_reg_dst(id_reg_dst), .id_alu_src(id_alu_src),
    .id_mem_to_reg(id_mem_to_reg), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_branch(id_branch), .id_alu_op(id_alu_op),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_branch_taken(ex_branch_taken),
    .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .ex_alu_op(ex_alu_op),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_dest(mem_dest),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write),
    .wb_dest(wb_dest),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // regDst, aluSrc, memToReg, regWrite, memRead, memWrite, branch, aluOp, rs, rt, rd
  task automatic setId(input int rd_dst, input int asrc, input int m2r, input int rw,
                       input int mr, input int mw, input int br, input int aop,
                       input int rs, input int rt, input int rd);
    id_reg_dst    = rd_dst[0];
    id_alu_src    = asrc[0];
    id_mem_to_reg = m2r[0];
    id_reg_write  = rw[0];
    id_mem_read   = mr[0];
    id_mem_write  = mw[0];
    id_branch     = br[0];
    id_alu_op     = aop[1:0];
    id_rs         = AW'(rs);
    id_rt         = AW'(rt);
    id_rd         = AW'(rd);
  endtask

  task automatic nop();
    setId(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic front(input string tag, input int pcw, input int ifw, input int ifl);
    #1;
    chk({tag, ".pc_write"}, 32'(pc_write), 32'(pcw));
    chk({tag, ".ifid_write"}, 32'(ifid_write), 32'(ifw));
    chk({tag, ".ifid_flush"}, 32'(ifid_flush), 32'(ifl));
  endtask

  task automatic allZero(input string tag);
    chk({tag, ".ex_ctrl"}, 32'({ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write,
                                ex_mem_read, ex_mem_write, ex_branch, ex_alu_op}), 0);
    chk({tag, ".ex_fields"}, 32'({ex_rs, ex_rt, ex_dest}), 0);
    chk({tag, ".mem"}, 32'({mem_mem_to_reg, mem_reg_write, mem_mem_read,
                            mem_mem_write, mem_dest}), 0);
    chk({tag, ".wb"}, 32'({wb_mem_to_reg, wb_reg_write, wb_dest}), 0);
  endtask

  initial begin
    ex_branch_taken = 1'b0;
    nop();
    // Reset state
    #12;
    allZero("reset");
    front("reset", 1, 1, 0);
    chk("reset.fwd", 32'({fwd_a, fwd_b}), 0);
    $display("reset: checked");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Pass-through R-type rd=5 rt=3
    setId(1, 0, 0, 1, 0, 0, 0, 2, 1, 3, 5);
    front("pass.id", 1, 1, 0);
    tick();
    chk("pass.ex_dest", 32'(ex_dest), 5);
    chk("pass.ex_ctrl", 32'({ex_reg_dst, ex_reg_write, ex_alu_op}), 32'b1110);
    chk("pass.ex_rsrt", 32'({ex_rs, ex_rt}), 32'({5'd1, 5'd3}));
    nop();
    tick();
    chk("pass.mem", 32'({mem_reg_write, mem_dest}), 32'({1'b1, 5'd5}));
    chk("pass.ex_empty", 32'(ex_dest), 0);
    tick();
    chk("pass.wb", 32'({wb_reg_write, wb_dest}), 32'({1'b1, 5'd5}));
    tick();
    $display("pass-through: checked");

    // Load-use: LW rt=8 then consumer rs=8
    setId(0, 1, 1, 1, 1, 0, 0, 0, 2, 8, 0);
    tick();
    chk("lu.ex_load", 32'({ex_mem_read, ex_dest}), 32'({1'b1, 5'd8}));
    setId(1, 0, 0, 1, 0, 0, 0, 2, 8, 4, 9);
    front("lu.stall1", 0, 0, 0);
    tick();
    chk("lu.bubble_ctrl", 32'({ex_reg_dst, ex_reg_write, ex_mem_read, ex_alu_op}), 0);
    chk("lu.bubble_fields", 32'({ex_rs, ex_rt, ex_dest}), 0);
    chk("lu.mem_adv", 32'({mem_mem_read, mem_dest}), 32'({1'b1, 5'd8}));
`ifdef FWD_UNIT_EN
    front("lu.resume", 1, 1, 0);
    tick();
    chk("lu.ex_consumer", 32'({ex_rs, ex_dest}), 32'({5'd8, 5'd9}));
    chk("lu.fwd_a", 32'(fwd_a), 32'(2'b01));
`else
    front("lu.stall2", 0, 0, 0);
    tick();
    chk("lu.wb_load", 32'({wb_reg_write, wb_dest}), 32'({1'b1, 5'd8}));
    front("lu.resume", 1, 1, 0);
    tick();
    chk("lu.ex_consumer", 32'({ex_rs, ex_dest}), 32'({5'd8, 5'd9}));
    chk("lu.fwd_a", 32'(fwd_a), 0);
`endif
    nop();
    tick(); tick(); tick();
    $display("load-use: checked");

    // Flush and load-use in the same cycle
    setId(0, 1, 1, 1, 1, 0, 0, 0, 2, 8, 0);
    tick();
    setId(1, 0, 0, 1, 0, 0, 0, 2, 8, 4, 9);
    ex_branch_taken = 1'b1;
    front("flush", 1, 1, 1);
    tick();
    ex_branch_taken = 1'b0;
    chk("flush.bubble", 32'({ex_reg_write, ex_rs, ex_dest}), 0);
    nop();
    front("flush.after", 1, 1, 0);
    tick(); tick(); tick();
    $display("flush-vs-stall: checked");

    // $0 immunity: LW rt=0, consumer rs=0
    setId(0, 1, 1, 1, 1, 0, 0, 0, 2, 0, 0);
    tick();
    setId(1, 0, 0, 1, 0, 0, 0, 2, 0, 0, 6);
    front("zero.nostall", 1, 1, 0);
    tick();
    chk("zero.ex", 32'({ex_reg_write, ex_dest}), 32'({1'b1, 5'd6}));
    chk("zero.fwd", 32'({fwd_a, fwd_b}), 0);
    nop();
    front("zero.next", 1, 1, 0);
    tick(); tick(); tick();
    $display("zero-reg: checked");

    // Back-to-back producers of 7, consumer rs=rt=7
    setId(1, 0, 0, 1, 0, 0, 0, 2, 1, 2, 7);
    tick();
    setId(1, 0, 0, 1, 0, 0, 0, 2, 1, 2, 7);
    front("prio.b", 1, 1, 0);
    tick();
    setId(1, 0, 0, 1, 0, 0, 0, 2, 7, 7, 10);
`ifdef FWD_UNIT_EN
    front("prio.c", 1, 1, 0);
    tick();
    chk("prio.stages", 32'({mem_dest, wb_dest, ex_rs}), 32'({5'd7, 5'd7, 5'd7}));
    chk("prio.fwd", 32'({fwd_a, fwd_b}), 32'(4'b1010));
`else
    front("prio.stall1", 0, 0, 0);
    tick();
    front("prio.stall2", 0, 0, 0);
    tick();
    front("prio.resume", 1, 1, 0);
    tick();
    chk("prio.ex_rs", 32'({ex_rs, ex_dest}), 32'({5'd7, 5'd10}));
    chk("prio.fwd", 32'({fwd_a, fwd_b}), 0);
`endif
    $display("forward-priority: checked");

    // Asynchronous reset mid-stream
    nop();
    chk("mrst.pre", 32'(ex_reg_write), 1);
    #2;
    rst_n = 1'b0;
    #1;
    allZero("mrst");
    front("mrst", 1, 1, 0);
    $display("mid-reset: checked");
    #3;
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
